// File: rtl/vjtag_mm_read_pkg.sv
// vjtag_mm_read_pkg: shared FSM encoding, Avalon tie-offs and default widths
package vjtag_mm_read_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int MAX_PEND_DEF = 4;
  localparam logic AV_CHIP_EN = 1'b1;
  localparam logic [1:0] AV_BYTE_EN = 2'b11;
  localparam logic AV_WRITE = 1'b0;
endpackage

// File: rtl/mm_read_fifo.sv
// mm_read_fifo: sync FIFO with first-word fall-through head and occupancy count
module mm_read_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (clr) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wr] <= din;
  assign head = mem[rd];
  assign empty = count == '0;
endmodule

// File: rtl/vjtag_mm_read.sv
// vjtag_mm_read: Avalon-MM block reader feeding an LSB-first JTAG TDO serialiser
module vjtag_mm_read
  import vjtag_mm_read_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic [ADDR_W-1:0] Base_Address,
  input  logic [LEN_W-1:0] Word_Count,
  output logic Busy,
  output logic Done,
  output logic Underrun,
  output logic Avalon_ChipEnable,
  output logic [1:0] Avalon_ByteEnable,
  output logic [ADDR_W-1:0] Avalon_Address,
  output logic Avalon_Read,
  input  logic Avalon_WaitRequest,
  input  logic [DATA_W-1:0] Avalon_ReadData,
  input  logic Avalon_ReadDataValid,
  output logic Avalon_Write,
  input  logic Capture_Strobe,
  input  logic Shift_Strobe,
  output logic TDO_Bit
);
  localparam int PW = $clog2(MAX_PEND+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = (PW > CW ? PW : CW) + 1;
  localparam int BW = $clog2(DATA_W);
  state_t state, state_nxt;
  logic [LEN_W-1:0] remaining, words_left;
  logic [PW-1:0] pending;
  logic [DATA_W-1:0] shreg, head;
  logic [BW-1:0] bitcnt;
  logic [CW-1:0] fifo_count;
  logic fifo_empty, start_ok, credit, accept, ret, push, pop, word_end, last_bit, load;
  assign Busy = state != IDLE;
  assign start_ok = Start && !Busy;
  assign credit = (SW'(pending) + SW'(fifo_count) < SW'(FIFO_DEPTH)) && (pending < PW'(MAX_PEND));
  assign Avalon_Read = state == FETCH && credit;
  assign accept = Avalon_Read && !Avalon_WaitRequest;
  assign ret = Avalon_ReadDataValid && pending != '0;
  assign word_end = Shift_Strobe && !Capture_Strobe && bitcnt == BW'(DATA_W-1);
  assign last_bit = Busy && word_end && words_left == LEN_W'(1);
  assign load = Busy && (Capture_Strobe || word_end) && !last_bit;
  assign pop = load && !fifo_empty;
  // Returns after the final bit or after a reset belong to no live transfer.
  assign push = ret && Busy && !last_bit;
  assign Avalon_ChipEnable = AV_CHIP_EN;
  assign Avalon_ByteEnable = AV_BYTE_EN;
  assign Avalon_Write = AV_WRITE;
  assign TDO_Bit = shreg[0];
  mm_read_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .clr(last_bit),
    .push(push),
    .pop(pop),
    .din(Avalon_ReadData),
    .head(head),
    .count(fifo_count),
    .empty(fifo_empty)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start_ok && Word_Count != '0) state_nxt = FETCH;
    else if (last_bit) state_nxt = IDLE;
    else if (state == FETCH && accept && remaining == LEN_W'(1)) state_nxt = DRAIN;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      Avalon_Address <= '0;
      remaining <= '0;
      words_left <= '0;
      pending <= '0;
      shreg <= '0;
      bitcnt <= '0;
      Underrun <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= (start_ok && Word_Count == '0) || last_bit;
      pending <= pending + PW'(accept) - PW'(ret);
      if (start_ok) begin
        Avalon_Address <= Base_Address;
        remaining <= Word_Count;
        words_left <= Word_Count;
        Underrun <= 1'b0;
      end else if (accept) begin
        Avalon_Address <= Avalon_Address + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (Busy && word_end) words_left <= words_left - 1'b1;
      if (load) begin
        shreg <= fifo_empty ? '0 : head;
        bitcnt <= '0;
        if (fifo_empty) Underrun <= 1'b1;
      end else if (last_bit || !Busy) begin
        shreg <= '0;
        bitcnt <= '0;
      end else if (Shift_Strobe) begin
        shreg <= shreg >> 1;
        bitcnt <= bitcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_vjtag_mm_read.sv
// tb_vjtag_mm_read: Avalon memory model + scoreboard of issued addresses and shifted words
module tb_vjtag_mm_read;
  logic Clk = 1'b0;
  logic Reset, Start, Busy, Done, Underrun;
  logic Avalon_ChipEnable, Avalon_Read, Avalon_WaitRequest, Avalon_ReadDataValid, Avalon_Write;
  logic [1:0] Avalon_ByteEnable;
  logic [24:0] Base_Address, Avalon_Address;
  logic [15:0] Word_Count, Avalon_ReadData;
  logic Capture_Strobe, Shift_Strobe, TDO_Bit;

  vjtag_mm_read dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Base_Address(Base_Address), .Word_Count(Word_Count),
    .Busy(Busy), .Done(Done), .Underrun(Underrun), .Avalon_ChipEnable(Avalon_ChipEnable),
    .Avalon_ByteEnable(Avalon_ByteEnable), .Avalon_Address(Avalon_Address), .Avalon_Read(Avalon_Read),
    .Avalon_WaitRequest(Avalon_WaitRequest), .Avalon_ReadData(Avalon_ReadData),
    .Avalon_ReadDataValid(Avalon_ReadDataValid), .Avalon_Write(Avalon_Write),
    .Capture_Strobe(Capture_Strobe), .Shift_Strobe(Shift_Strobe), .TDO_Bit(TDO_Bit)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [15:0] d; int due; } rsp_t;
  typedef struct { logic [24:0] base; logic [15:0] count; int lat; int wait_pct; int gap; logic exp_underrun; } vec_t;

  int tests = 0, fails = 0;
  int lat = 1, wait_pct = 0, ncyc = 0, outstanding = 0, max_out = 0;
  int accepts = 0, read_cycles = 0, done_cnt = 0, exp_done = 0;
  rsp_t rsp_q[$];
  logic [24:0] exp_addr_q[$];
  logic [15:0] exp_word_q[$];
  logic stalled_prev = 1'b0;
  logic [24:0] addr_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    if (a == 25'h100) return 16'hA5A5;
    if (a == 25'h101) return 16'h0001;
    if (a == 25'h102) return 16'h8000;
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  // Memory slave: decisions made on the falling edge for the following rising edge.
  always @(negedge Clk) begin
    ncyc++;
    if (stalled_prev && !Reset) check("stall_hold", {6'd0, Avalon_Read, Avalon_Address}, {6'd0, 1'b1, addr_prev});
    if (Avalon_ReadDataValid) outstanding--;
    Avalon_WaitRequest = $urandom_range(99) < wait_pct;
    Avalon_ReadDataValid = 1'b0;
    Avalon_ReadData = 16'hDEAD;
    if (rsp_q.size() != 0 && rsp_q[0].due <= ncyc) begin
      Avalon_ReadDataValid = 1'b1;
      Avalon_ReadData = rsp_q[0].d;
      void'(rsp_q.pop_front());
    end
    if (Avalon_Read) read_cycles++;
    if (Avalon_Read && !Avalon_WaitRequest && !Reset) begin
      accepts++;
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
      if (exp_addr_q.size() != 0) check("addr", Avalon_Address, exp_addr_q.pop_front());
      else begin
        tests++;
        fails++;
        $display("FAIL addr_extra: got read of %h expected none", Avalon_Address);
      end
      rsp_q.push_back('{mem_word(Avalon_Address), ncyc + lat});
    end
    stalled_prev = Avalon_Read && Avalon_WaitRequest && !Reset;
    addr_prev = Avalon_Address;
    if (Done) done_cnt++;
  end

  task automatic do_start(input logic [24:0] b, input logic [15:0] n);
    @(negedge Clk);
    Base_Address = b;
    Word_Count = n;
    Start = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(25'(b + 25'(i)));
      exp_word_q.push_back(mem_word(25'(b + 25'(i))));
    end
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic capture();
    @(negedge Clk);
    Capture_Strobe = 1'b1;
    @(negedge Clk);
    Capture_Strobe = 1'b0;
  endtask

  task automatic shift_word(output logic [15:0] w, input int gap);
    for (int i = 0; i < 16; i++) begin
      repeat (gap) @(negedge Clk);
      @(negedge Clk);
      w[i] = TDO_Bit;
      Shift_Strobe = 1'b1;
      @(negedge Clk);
      Shift_Strobe = 1'b0;
    end
  endtask

  task automatic finish_check(input string name);
    check({name, "_done"}, Done, 1'b1);
    check({name, "_busy"}, Busy, 1'b0);
    exp_done++;
  endtask

  vec_t vecs[4];

  initial begin
    logic [15:0] w, e0;
    int a0, r0, budget;
    vecs[0] = '{25'h100, 16'd3, 1, 0, 0, 1'b0};
    vecs[1] = '{25'h1FFFFFE, 16'd5, 3, 50, 1, 1'b0};
    vecs[2] = '{25'h2345, 16'd8, 2, 50, 0, 1'b0};
    vecs[3] = '{25'h0, 16'd1, 1, 0, 0, 1'b0};
    Reset = 1'b1;
    Start = 1'b0;
    Base_Address = '0;
    Word_Count = '0;
    Capture_Strobe = 1'b0;
    Shift_Strobe = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_outs", {Busy, Done, Underrun, Avalon_Read, TDO_Bit}, 5'b0);
    check("reset_addr", Avalon_Address, 25'h0);
    check("tieoffs", {Avalon_ChipEnable, Avalon_ByteEnable, Avalon_Write}, 4'b1110);
    Reset = 1'b0;

    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      wait_pct = vecs[v].wait_pct;
      max_out = 0;
      a0 = accepts;
      do_start(vecs[v].base, vecs[v].count);
      check("vec_busy", Busy, 1'b1);
      repeat (30) @(negedge Clk);
      capture();
      for (int i = 0; i < int'(vecs[v].count); i++) begin
        shift_word(w, vecs[v].gap);
        check("vec_word", w, exp_word_q.pop_front());
      end
      finish_check("vec");
      check("vec_underrun", Underrun, vecs[v].exp_underrun);
      check("vec_accepts", accepts - a0, vecs[v].count);
      check("vec_addr_left", exp_addr_q.size(), 0);
      check("vec_max_pend_ok", max_out <= 4, 1'b1);
      wait_pct = 0;
      repeat (10) @(negedge Clk);
    end

    // FIFO fills to depth with no shifting, then reads resume as it drains.
    lat = 2;
    wait_pct = 0;
    a0 = accepts;
    do_start(25'h4000, 16'd40);
    repeat (200) @(negedge Clk);
    check("fill_accepts", accepts - a0, 16);
    check("fill_read_idle", Avalon_Read, 1'b0);
    capture();
    for (int i = 0; i < 40; i++) begin
      shift_word(w, 0);
      check("fill_word", w, exp_word_q.pop_front());
    end
    finish_check("fill");
    check("fill_accepts_all", accepts - a0, 40);
    repeat (10) @(negedge Clk);

    // Shifting outruns a slow memory.
    lat = 20;
    do_start(25'h500, 16'd2);
    capture();
    check("urun_flag", Underrun, 1'b1);
    shift_word(w, 0);
    check("urun_zero", w, 16'h0);
    e0 = exp_word_q.pop_front();
    void'(exp_word_q.pop_front());
    shift_word(w, 0);
    check("urun_late_word", w, e0);
    finish_check("urun");
    check("urun_sticky", Underrun, 1'b1);
    repeat (40) @(negedge Clk);
    lat = 1;
    do_start(25'h600, 16'd1);
    check("urun_cleared", Underrun, 1'b0);
    repeat (30) @(negedge Clk);
    capture();
    shift_word(w, 0);
    check("urun_next_word", w, exp_word_q.pop_front());
    finish_check("urun_next");
    repeat (5) @(negedge Clk);

    // Zero-length transfer.
    r0 = read_cycles;
    do_start(25'h700, 16'd0);
    check("zero_done", Done, 1'b1);
    check("zero_busy", Busy, 1'b0);
    exp_done++;
    @(negedge Clk);
    check("zero_done_pulse", Done, 1'b0);
    repeat (10) @(negedge Clk);
    check("zero_no_read", read_cycles - r0, 0);

    // A second Start during a transfer is ignored.
    a0 = accepts;
    do_start(25'h800, 16'd2);
    repeat (3) @(negedge Clk);
    Base_Address = 25'h900;
    Word_Count = 16'd7;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (30) @(negedge Clk);
    capture();
    for (int i = 0; i < 2; i++) begin
      shift_word(w, 0);
      check("busy_start_word", w, exp_word_q.pop_front());
    end
    finish_check("busy_start");
    check("busy_start_accepts", accepts - a0, 2);
    repeat (5) @(negedge Clk);

    // Reset with reads in flight; their late data must not land in the FIFO.
    lat = 20;
    do_start(25'hA00, 16'd8);
    budget = 50;
    while (outstanding < 3 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    check("rst_pending_reached", outstanding >= 3, 1'b1);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_outs", {Busy, Done, Underrun, Avalon_Read, TDO_Bit}, 5'b0);
    check("rst_mid_addr", Avalon_Address, 25'h0);
    @(negedge Clk);
    Reset = 1'b0;
    exp_addr_q.delete();
    exp_word_q.delete();
    repeat (40) @(negedge Clk);
    do_start(25'hB00, 16'd1);
    capture();
    check("rst_fifo_empty", Underrun, 1'b1);
    shift_word(w, 0);
    check("rst_zero_word", w, 16'h0);
    finish_check("rst_next");
    repeat (40) @(negedge Clk);
    check("done_pulses", done_cnt, exp_done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule
